// File: rtl/risc_pkg.sv
// -----------------------------------------------------------------------------
// risc_pkg
// Shared definitions for the 16-bit RISC core execute stage.
//   - WIDTH / OPW    : datapath and opcode widths
//   - OP_* constants : opcode encoding (instruction bits [15:12])
//   - opcode_t       : opcode field type
//   - word_t         : datapath word type
//   - helper functions classifying opcodes
// -----------------------------------------------------------------------------
package risc_pkg;

    localparam int WIDTH = 16;
    localparam int OPW   = 4;

    typedef logic [OPW-1:0]   opcode_t;
    typedef logic [WIDTH-1:0] word_t;

    localparam opcode_t OP_AND  = 4'd0;
    localparam opcode_t OP_ADD  = 4'd1;
    localparam opcode_t OP_SUB  = 4'd2;
    localparam opcode_t OP_ADDI = 4'd3;
    localparam opcode_t OP_ANDI = 4'd4;
    localparam opcode_t OP_LW   = 4'd5;
    localparam opcode_t OP_LBX  = 4'd6;
    localparam opcode_t OP_SW   = 4'd7;
    localparam opcode_t OP_BGT  = 4'd8;
    localparam opcode_t OP_BLT  = 4'd9;
    localparam opcode_t OP_BEQ  = 4'd10;
    localparam opcode_t OP_BNE  = 4'd11;
    localparam opcode_t OP_JMP  = 4'd12;
    localparam opcode_t OP_CALL = 4'd13;
    localparam opcode_t OP_RET  = 4'd14;
    localparam opcode_t OP_SV   = 4'd15;

    // Control-transfer opcodes leave the ALU result (and flags) untouched.
    function automatic logic is_hold_op(input opcode_t op);
        logic r;
        case (op)
            OP_JMP, OP_CALL, OP_RET: r = 1'b1;
            default:                 r = 1'b0;
        endcase
        return r;
    endfunction

    // Opcodes whose ALU result is a - b.
    function automatic logic is_sub_op(input opcode_t op);
        logic r;
        case (op)
            OP_SUB, OP_BGT, OP_BLT, OP_BEQ, OP_BNE: r = 1'b1;
            default:                               r = 1'b0;
        endcase
        return r;
    endfunction

endpackage : risc_pkg

// File: rtl/branch_comparator.sv
// -----------------------------------------------------------------------------
// branch_comparator
// Combinational signed branch-condition evaluator.
// Ports:
//   opcode   in  : instruction opcode; only BGT/BLT/BEQ/BNE produce a condition
//   a        in  : operand A (left operand when cmp_mode = 0)
//   b        in  : operand B (always the right operand)
//   cmp_mode in  : 1 selects zero as the left operand (compare-against-zero)
//   cond     out : branch condition true
// -----------------------------------------------------------------------------
module branch_comparator
    import risc_pkg::*;
(
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cmp_mode,
    output logic             cond
);

    logic [WIDTH-1:0] lhs_s;

    // Left-operand select: zero or operand A.
    always_comb begin
        if (cmp_mode) begin
            lhs_s = {WIDTH{1'b0}};
        end else begin
            lhs_s = a;
        end
    end

    // Signed two's-complement compare selected by opcode; non-branches give 0.
    always_comb begin
        cond = 1'b0;
        case (opcode)
            OP_BGT:  cond = ($signed(lhs_s) >  $signed(b));
            OP_BLT:  cond = ($signed(lhs_s) <  $signed(b));
            OP_BEQ:  cond = (lhs_s == b);
            OP_BNE:  cond = (lhs_s != b);
            default: cond = 1'b0;
        endcase
    end

endmodule : branch_comparator

// File: rtl/exec_alu_cmp.sv
// -----------------------------------------------------------------------------
// exec_alu_cmp
// Execute stage of the 16-bit RISC core: ALU plus branch comparator, with the
// ALU result and branch-taken flag registered on every enabled cycle.
// Ports:
//   clock        in  : rising-edge clock
//   reset        in  : synchronous, active-high; clears all outputs
//   en           in  : execute enable; outputs update only when high
//   opcode       in  : instruction opcode (instruction bits [15:12])
//   a            in  : operand A (register-file bus A)
//   b            in  : operand B (bus B or extended immediate)
//   cmp_mode     in  : 1 = comparator left operand is zero, 0 = operand A
//   result       out : registered ALU result
//   branch_flag  out : registered branch condition
//   result_valid out : pulses high the cycle after each enabled cycle
//   flag_n/z/c/v out : registered ALU status flags (only with ALU_FLAGS_EN)
// Configuration macro: ALU_FLAGS_EN adds the registered N/Z/C/V flag outputs.
// -----------------------------------------------------------------------------
module exec_alu_cmp
    import risc_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cmp_mode,
    output logic [WIDTH-1:0] result,
    output logic             branch_flag,
    output logic             result_valid
`ifdef ALU_FLAGS_EN
    ,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
`endif
);

    // ---------------------------------------------------------------------
    // Arithmetic
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] add_sum_s;
    logic [WIDTH-1:0] sub_diff_s;

`ifdef ALU_FLAGS_EN
    logic             add_c_s;
    logic             sub_c_s;

    // Subtraction as a + ~b + 1 so the carry out is the inverted borrow.
    assign {add_c_s, add_sum_s}  = {1'b0, a} + {1'b0, b};
    assign {sub_c_s, sub_diff_s} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
`else
    assign add_sum_s  = a + b;
    assign sub_diff_s = a - b;
`endif

    // ---------------------------------------------------------------------
    // Branch comparator
    // ---------------------------------------------------------------------
    logic cond_s;

    branch_comparator u_branch_comparator (
        .opcode   (opcode),
        .a        (a),
        .b        (b),
        .cmp_mode (cmp_mode),
        .cond     (cond_s)
    );

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic             branch_flag_q;
    logic             branch_flag_d;
    logic             result_valid_q;
    logic             result_valid_d;
    logic [WIDTH-1:0] alu_res_s;

    // ALU function select; control-transfer ops recirculate the held result.
    always_comb begin
        alu_res_s = result_q;
        case (opcode)
            OP_AND, OP_ANDI:                    alu_res_s = a & b;
            OP_ADD, OP_ADDI, OP_LW, OP_LBX,
            OP_SW, OP_SV:                       alu_res_s = add_sum_s;
            OP_SUB, OP_BGT, OP_BLT, OP_BEQ,
            OP_BNE:                             alu_res_s = sub_diff_s;
            OP_JMP, OP_CALL, OP_RET:            alu_res_s = result_q;
            default:                            alu_res_s = result_q;
        endcase
    end

    // Next-state for the result, branch flag and valid strobe.
    always_comb begin
        result_d       = result_q;
        branch_flag_d  = branch_flag_q;
        result_valid_d = 1'b0;
        if (en) begin
            result_d       = alu_res_s;
            branch_flag_d  = cond_s;
            result_valid_d = 1'b1;
        end else begin
            result_d       = result_q;
            branch_flag_d  = branch_flag_q;
            result_valid_d = 1'b0;
        end
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            result_q       <= {WIDTH{1'b0}};
            branch_flag_q  <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            result_q       <= result_d;
            branch_flag_q  <= branch_flag_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign result       = result_q;
    assign branch_flag  = branch_flag_q;
    assign result_valid = result_valid_q;

`ifdef ALU_FLAGS_EN
    // ---------------------------------------------------------------------
    // Status flags
    // ---------------------------------------------------------------------
    logic alu_c_s;
    logic alu_v_s;
    logic flag_n_q, flag_n_d;
    logic flag_z_q, flag_z_d;
    logic flag_c_q, flag_c_d;
    logic flag_v_q, flag_v_d;

    // Carry / overflow per operation class; logic ops clear both.
    always_comb begin
        alu_c_s = 1'b0;
        alu_v_s = 1'b0;
        if (is_sub_op(opcode)) begin
            alu_c_s = sub_c_s;
            // Overflow when operand signs differ and the result sign differs from a.
            alu_v_s = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff_s[WIDTH-1] != a[WIDTH-1]);
        end else if ((opcode == OP_AND) || (opcode == OP_ANDI) || is_hold_op(opcode)) begin
            alu_c_s = 1'b0;
            alu_v_s = 1'b0;
        end else begin
            alu_c_s = add_c_s;
            // Overflow when operand signs match and the result sign differs.
            alu_v_s = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum_s[WIDTH-1] != a[WIDTH-1]);
        end
    end

    // Flags follow the result; control-transfer ops hold them along with it.
    always_comb begin
        flag_n_d = flag_n_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        flag_v_d = flag_v_q;
        if (en && !is_hold_op(opcode)) begin
            flag_n_d = alu_res_s[WIDTH-1];
            flag_z_d = (alu_res_s == {WIDTH{1'b0}});
            flag_c_d = alu_c_s;
            flag_v_d = alu_v_s;
        end else begin
            flag_n_d = flag_n_q;
            flag_z_d = flag_z_q;
            flag_c_d = flag_c_q;
            flag_v_d = flag_v_q;
        end
    end

    // Flag registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
        end else begin
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
            flag_v_q <= flag_v_d;
        end
    end

    assign flag_n = flag_n_q;
    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
    assign flag_v = flag_v_q;
`endif

endmodule : exec_alu_cmp

// File: tb/tb_exec_alu_cmp.sv
// -----------------------------------------------------------------------------
// tb_exec_alu_cmp
// Directed self-checking bench for exec_alu_cmp. Each step applies one set of
// inputs, waits for the rising edge, and compares the registered outputs with
// hand-computed values. Define ALU_FLAGS_EN to also check the status flags.
// -----------------------------------------------------------------------------
module tb_exec_alu_cmp;
    import risc_pkg::*;

    logic             clock;
    logic             reset;
    logic             en;
    logic [OPW-1:0]   opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cmp_mode;
    logic [WIDTH-1:0] result;
    logic             branch_flag;
    logic             result_valid;
`ifdef ALU_FLAGS_EN
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
`endif

    int checks_cnt   = 0;
    int failures_cnt = 0;

    exec_alu_cmp dut (
        .clock        (clock),
        .reset        (reset),
        .en           (en),
        .opcode       (opcode),
        .a            (a),
        .b            (b),
        .cmp_mode     (cmp_mode),
        .result       (result),
        .branch_flag  (branch_flag),
        .result_valid (result_valid)
`ifdef ALU_FLAGS_EN
        ,
        .flag_n       (flag_n),
        .flag_z       (flag_z),
        .flag_c       (flag_c),
        .flag_v       (flag_v)
`endif
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks_cnt++;
        if (obs !== exp_v) begin
            failures_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Apply inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic en_i, input logic [OPW-1:0] op_i,
                        input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                        input logic cm_i);
        en       = en_i;
        opcode   = op_i;
        a        = a_i;
        b        = b_i;
        cmp_mode = cm_i;
        @(posedge clock);
        #1;
    endtask

    // Check result / branch_flag / result_valid in one call.
    task automatic check_out(input string tag, input logic [WIDTH-1:0] r,
                             input logic bf, input logic rv);
        check_eq({tag, ".result"}, 32'(result), 32'(r));
        check_eq({tag, ".branch_flag"}, 32'(branch_flag), 32'(bf));
        check_eq({tag, ".result_valid"}, 32'(result_valid), 32'(rv));
    endtask

`ifdef ALU_FLAGS_EN
    task automatic check_flags(input string tag, input logic n, input logic z,
                               input logic c, input logic v);
        check_eq({tag, ".nzcv"}, {28'd0, flag_n, flag_z, flag_c, flag_v},
                 {28'd0, n, z, c, v});
    endtask
`endif

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        opcode   = OP_AND;
        a        = 16'h0000;
        b        = 16'h0000;
        cmp_mode = 1'b0;

        // Reset together with en: operation dropped.
        step(1'b1, OP_ADD, 16'h0005, 16'h0003, 1'b0);
        check_out("reset_with_en", 16'h0000, 1'b0, 1'b0);
`ifdef ALU_FLAGS_EN
        check_flags("reset_with_en", 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        reset = 1'b0;

        // Signed overflow boundary on add.
        step(1'b1, OP_ADD, 16'h7FFF, 16'h0001, 1'b0);
        check_out("add_ovf", 16'h8000, 1'b0, 1'b1);
`ifdef ALU_FLAGS_EN
        check_flags("add_ovf", 1'b1, 1'b0, 1'b0, 1'b1);
`endif

        step(1'b1, OP_SUB, 16'h0003, 16'h0005, 1'b0);
        check_out("sub_neg", 16'hFFFE, 1'b0, 1'b1);
`ifdef ALU_FLAGS_EN
        check_flags("sub_neg", 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        // Wrap to zero with carry out discarded.
        step(1'b1, OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
        check_out("add_wrap", 16'h0000, 1'b0, 1'b1);
`ifdef ALU_FLAGS_EN
        check_flags("add_wrap", 1'b0, 1'b1, 1'b1, 1'b0);
`endif

        // CALL holds result (and flags).
        step(1'b1, OP_CALL, 16'h1111, 16'h2222, 1'b0);
        check_out("call_hold", 16'h0000, 1'b0, 1'b1);
`ifdef ALU_FLAGS_EN
        check_flags("call_hold", 1'b0, 1'b1, 1'b1, 1'b0);
`endif

        step(1'b1, OP_AND, 16'hF0F0, 16'h3C3C, 1'b0);
        check_out("and", 16'h3030, 1'b0, 1'b1);

        // en low for three cycles: outputs hold, valid drops.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, OP_ADD, 16'h1111, 16'h1111, 1'b0);
            check_out("en_low_hold", 16'h3030, 1'b0, 1'b0);
        end

        // Signed compare: 0x8000 < 0x7FFF.
        step(1'b1, OP_BLT, 16'h8000, 16'h7FFF, 1'b0);
        check_out("blt_signed", 16'h0001, 1'b1, 1'b1);

        step(1'b0, OP_BGT, 16'h0000, 16'h0000, 1'b0);
        check_out("flag_hold", 16'h0001, 1'b1, 1'b0);

        step(1'b1, OP_BGT, 16'h8000, 16'h7FFF, 1'b0);
        check_out("bgt_signed", 16'h0001, 1'b0, 1'b1);

        step(1'b1, OP_BGT, 16'h0005, 16'h0003, 1'b0);
        check_out("bgt_true", 16'h0002, 1'b1, 1'b1);

        // Compare-against-zero mode ignores a for the comparison.
        step(1'b1, OP_BEQ, 16'h1234, 16'h0000, 1'b1);
        check_out("beq_zero", 16'h1234, 1'b1, 1'b1);

        step(1'b1, OP_BNE, 16'h1234, 16'h0000, 1'b1);
        check_out("bne_zero", 16'h1234, 1'b0, 1'b1);

        step(1'b1, OP_BLT, 16'h1234, 16'h0001, 1'b1);
        check_out("blt_zero", 16'h1233, 1'b1, 1'b1);

        step(1'b1, OP_BEQ, 16'h1234, 16'h1234, 1'b0);
        check_out("beq_eq", 16'h0000, 1'b1, 1'b1);

        // JMP after ADD keeps the ADD result.
        step(1'b1, OP_ADD, 16'h0005, 16'h0003, 1'b0);
        check_out("add_small", 16'h0008, 1'b0, 1'b1);
        step(1'b1, OP_JMP, 16'hAAAA, 16'h0001, 1'b0);
        check_out("jmp_hold", 16'h0008, 1'b0, 1'b1);
        step(1'b1, OP_RET, 16'h5555, 16'h0001, 1'b0);
        check_out("ret_hold", 16'h0008, 1'b0, 1'b1);

        // Remaining opcode decode.
        step(1'b1, OP_ADDI, 16'h0010, 16'h0020, 1'b0);
        check_out("addi", 16'h0030, 1'b0, 1'b1);
        step(1'b1, OP_ANDI, 16'hFFFF, 16'h00FF, 1'b0);
        check_out("andi", 16'h00FF, 1'b0, 1'b1);
        step(1'b1, OP_LW, 16'h0100, 16'h0004, 1'b0);
        check_out("lw", 16'h0104, 1'b0, 1'b1);
        step(1'b1, OP_LBX, 16'h0001, 16'h0001, 1'b0);
        check_out("lbx", 16'h0002, 1'b0, 1'b1);
        step(1'b1, OP_SW, 16'h0002, 16'h0002, 1'b0);
        check_out("sw", 16'h0004, 1'b0, 1'b1);
        step(1'b1, OP_SV, 16'h0007, 16'h0008, 1'b0);
        check_out("sv", 16'h000F, 1'b0, 1'b1);

        // Reset mid-run with en high clears everything.
        step(1'b1, OP_BLT, 16'h8000, 16'h7FFF, 1'b0);
        check_out("pre_reset", 16'h0001, 1'b1, 1'b1);
        reset = 1'b1;
        step(1'b1, OP_ADD, 16'h0005, 16'h0003, 1'b0);
        check_out("reset_mid", 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
        step(1'b0, OP_ADD, 16'h0005, 16'h0003, 1'b0);
        check_out("post_reset_idle", 16'h0000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule : tb_exec_alu_cmp
